// File: rtl/bist_pkg.sv
// Shared definitions for the memory BIST engine: FSM state codes, the
// March C- element table and the background selector encodings.
package bist_pkg;

    // FSM state codes
    typedef logic [2:0] state_t;
    localparam state_t ST_IDLE  = 3'd0;
    localparam state_t ST_WRITE = 3'd1;
    localparam state_t ST_READ  = 3'd2;
    localparam state_t ST_CMP   = 3'd3;
    localparam state_t ST_DONE  = 3'd4;

    // March element index, M0..M5
    typedef logic [2:0] elem_idx_t;
    localparam elem_idx_t ELEM_FIRST = 3'd0;
    localparam elem_idx_t ELEM_LAST  = 3'd5;

    // Background selector: pass 0 uses solid words, pass 1 checkerboard words
    localparam logic BG_SOLID   = 1'b0;
    localparam logic BG_CHECKER = 1'b1;

    // One march element: direction, optional read with its polarity,
    // optional write with its polarity (polarity 0 = background, 1 = inverse)
    typedef struct packed {
        logic down;
        logic has_read;
        logic rd_pol;
        logic has_write;
        logic wr_pol;
    } march_elem_t;

    // March C-: M0 U(w0) M1 U(r0,w1) M2 U(r1,w0) M3 D(r0,w1) M4 D(r1,w0) M5 U(r0)
    function automatic march_elem_t march_elem(input elem_idx_t idx);
        march_elem_t e;
        case (idx)
            3'd0:    e = '{down: 1'b0, has_read: 1'b0, rd_pol: 1'b0, has_write: 1'b1, wr_pol: 1'b0};
            3'd1:    e = '{down: 1'b0, has_read: 1'b1, rd_pol: 1'b0, has_write: 1'b1, wr_pol: 1'b1};
            3'd2:    e = '{down: 1'b0, has_read: 1'b1, rd_pol: 1'b1, has_write: 1'b1, wr_pol: 1'b0};
            3'd3:    e = '{down: 1'b1, has_read: 1'b1, rd_pol: 1'b0, has_write: 1'b1, wr_pol: 1'b1};
            3'd4:    e = '{down: 1'b1, has_read: 1'b1, rd_pol: 1'b1, has_write: 1'b1, wr_pol: 1'b0};
            default: e = '{down: 1'b0, has_read: 1'b1, rd_pol: 1'b0, has_write: 1'b0, wr_pol: 1'b0};
        endcase
        return e;
    endfunction

    // Every element starts with its read if it has one, otherwise its write
    function automatic state_t first_state(input march_elem_t e);
        return e.has_read ? ST_READ : ST_WRITE;
    endfunction

endpackage

// File: rtl/bist_addr_gen.sv
// Up/down address counter for the march elements. Load picks the start
// address of an element (0 ascending, DEPTH-1 descending); last flags the
// final address in the current direction.
module bist_addr_gen #(
    parameter int ADDR_WIDTH = 2,
    parameter int DEPTH      = 4
) (
    input  logic                  clk,
    input  logic                  res,
    input  logic                  load_i,
    input  logic                  load_down_i,
    input  logic                  step_i,
    input  logic                  dir_down_i,
    output logic [ADDR_WIDTH-1:0] addr_o,
    output logic                  last_o
);

    localparam logic [ADDR_WIDTH-1:0] ADDR_TOP = ADDR_WIDTH'(DEPTH - 1);

    logic [ADDR_WIDTH-1:0] addr_q;
    logic [ADDR_WIDTH-1:0] addr_d;

    // Next address: load wins over step; otherwise hold
    always_comb begin
        addr_d = addr_q;
        if (load_i) begin
            addr_d = load_down_i ? ADDR_TOP : '0;
        end else if (step_i) begin
            addr_d = dir_down_i ? addr_q - 1'b1 : addr_q + 1'b1;
        end
    end

    // Address register
    always_ff @(posedge clk) begin
        if (res) begin
            addr_q <= '0;
        end else begin
            addr_q <= addr_d;
        end
    end

    assign addr_o = addr_q;
    assign last_o = dir_down_i ? (addr_q == '0) : (addr_q == ADDR_TOP);

endmodule

// File: rtl/memory_bist.sv
// March C- BIST engine for a single-port memory. Runs the march twice
// (solid then checkerboard background) and stops at the first mismatch,
// recording its address, read value and expected value.
module memory_bist
    import bist_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 2,
    parameter int DEPTH      = 4,
    parameter int SYNC_READ  = 1
) (
    input  logic                  clk,
    input  logic                  res,
    input  logic                  start,
    output logic                  mem_wen,
    output logic                  mem_ren,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wr_data,
    input  logic [DATA_WIDTH-1:0] mem_rd_data,
    output logic                  busy,
    output logic                  done,
    output logic                  fail,
    output logic [ADDR_WIDTH-1:0] fail_addr,
    output logic [DATA_WIDTH-1:0] fail_data,
    output logic [DATA_WIDTH-1:0] fail_exp
);

    state_t                state_q, state_d;
    elem_idx_t             elem_q, elem_d;
    logic                  pass_q, pass_d;
    logic                  fail_q, fail_d;
    logic [ADDR_WIDTH-1:0] fail_addr_q, fail_addr_d;
    logic [DATA_WIDTH-1:0] fail_data_q, fail_data_d;
    logic [DATA_WIDTH-1:0] fail_exp_q, fail_exp_d;

    logic                  ag_load, ag_load_down, ag_step, ag_last;
    logic [ADDR_WIDTH-1:0] ag_addr;

    march_elem_t           elem;
    elem_idx_t             next_elem;
    logic [DATA_WIDTH-1:0] checker_word, bg0_word, bg1_word, exp_word, wr_word;
    logic                  cmp_now, mismatch;

    // Checkerboard word 0x55.. : even bits set, works for odd widths too
    for (genvar gi = 0; gi < DATA_WIDTH; gi++) begin : g_checker
        assign checker_word[gi] = ((gi % 2) == 0);
    end

    assign elem      = march_elem(elem_q);
    assign next_elem = (elem_q == ELEM_LAST) ? ELEM_FIRST : elem_q + 3'd1;
    assign bg0_word  = (pass_q == BG_CHECKER) ? checker_word  : '0;
    assign bg1_word  = (pass_q == BG_CHECKER) ? ~checker_word : '1;
    assign exp_word  = elem.rd_pol ? bg1_word : bg0_word;
    assign wr_word   = elem.wr_pol ? bg1_word : bg0_word;

    // With an async memory the read data is already valid in READ
    assign cmp_now  = (state_q == ST_CMP) || ((state_q == ST_READ) && (SYNC_READ == 0));
    assign mismatch = cmp_now && (mem_rd_data != exp_word);

    bist_addr_gen #(
        .ADDR_WIDTH(ADDR_WIDTH),
        .DEPTH     (DEPTH)
    ) u_addr_gen (
        .clk        (clk),
        .res        (res),
        .load_i     (ag_load),
        .load_down_i(ag_load_down),
        .step_i     (ag_step),
        .dir_down_i (elem.down),
        .addr_o     (ag_addr),
        .last_o     (ag_last)
    );

    // Sequencing: op -> next op, address, element and pass, all decided in the op's own cycle
    always_comb begin
        state_d      = state_q;
        elem_d       = elem_q;
        pass_d       = pass_q;
        fail_d       = fail_q;
        fail_addr_d  = fail_addr_q;
        fail_data_d  = fail_data_q;
        fail_exp_d   = fail_exp_q;
        ag_load      = 1'b0;
        ag_load_down = 1'b0;
        ag_step      = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d      = first_state(march_elem(ELEM_FIRST));
                    elem_d       = ELEM_FIRST;
                    pass_d       = BG_SOLID;
                    fail_d       = 1'b0;
                    fail_addr_d  = '0;
                    fail_data_d  = '0;
                    fail_exp_d   = '0;
                    ag_load      = 1'b1;
                    ag_load_down = march_elem(ELEM_FIRST).down;
                end
            end
            ST_WRITE, ST_READ, ST_CMP: begin
                if (mismatch) begin
                    state_d     = ST_DONE;
                    fail_d      = 1'b1;
                    fail_addr_d = ag_addr;
                    fail_data_d = mem_rd_data;
                    fail_exp_d  = exp_word;
                end else if ((state_q == ST_READ) && (SYNC_READ != 0)) begin
                    state_d = ST_CMP;
                end else if ((state_q != ST_WRITE) && elem.has_write) begin
                    state_d = ST_WRITE;
                end else if (!ag_last) begin
                    ag_step = 1'b1;
                    state_d = first_state(elem);
                end else if ((elem_q == ELEM_LAST) && (pass_q == BG_CHECKER)) begin
                    state_d = ST_DONE;
                end else begin
                    elem_d       = next_elem;
                    pass_d       = (elem_q == ELEM_LAST) ? BG_CHECKER : pass_q;
                    ag_load      = 1'b1;
                    ag_load_down = march_elem(next_elem).down;
                    state_d      = first_state(march_elem(next_elem));
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Control and result registers
    always_ff @(posedge clk) begin
        if (res) begin
            state_q     <= ST_IDLE;
            elem_q      <= ELEM_FIRST;
            pass_q      <= BG_SOLID;
            fail_q      <= 1'b0;
            fail_addr_q <= '0;
            fail_data_q <= '0;
            fail_exp_q  <= '0;
        end else begin
            state_q     <= state_d;
            elem_q      <= elem_d;
            pass_q      <= pass_d;
            fail_q      <= fail_d;
            fail_addr_q <= fail_addr_d;
            fail_data_q <= fail_data_d;
            fail_exp_q  <= fail_exp_d;
        end
    end

    assign busy        = (state_q == ST_WRITE) || (state_q == ST_READ) || (state_q == ST_CMP);
    assign done        = (state_q == ST_DONE);
    assign mem_wen     = (state_q == ST_WRITE);
    assign mem_ren     = (state_q == ST_READ);
    assign mem_wr_data = (state_q == ST_WRITE) ? wr_word : '0;
    assign mem_addr    = ag_addr;
    assign fail        = fail_q;
    assign fail_addr   = fail_addr_q;
    assign fail_data   = fail_data_q;
    assign fail_exp    = fail_exp_q;

endmodule

// File: tb/tb_memory_bist.sv
// Bench for memory_bist: one sync-read and one async-read instance run side
// by side on fault-injectable memory models. Expected results come from an
// algorithmic March C- model and are queued per instance; monitors compare
// when done rises.
module tb_memory_bist;

    localparam int DEPTH = 4;

    // March C- table, bit e = element Me
    localparam logic [5:0] EL_DOWN = 6'b011000;
    localparam logic [5:0] EL_RD   = 6'b111110;
    localparam logic [5:0] EL_RPOL = 6'b010100;
    localparam logic [5:0] EL_WR   = 6'b011111;
    localparam logic [5:0] EL_WPOL = 6'b001010;

    typedef struct packed {
        logic        fail;
        logic [1:0]  addr;
        logic [7:0]  data;
        logic [7:0]  expv;
        logic [31:0] len;
    } exp_t;

    logic clk = 1'b0;
    logic res = 1'b1;
    logic start = 1'b0;

    logic       mem_wen_w     [2];
    logic       mem_ren_w     [2];
    logic [1:0] mem_addr_w    [2];
    logic [7:0] mem_wr_data_w [2];
    logic       busy_w        [2];
    logic       done_w        [2];
    logic       fail_w        [2];
    logic [1:0] fail_addr_w   [2];
    logic [7:0] fail_data_w   [2];
    logic [7:0] fail_exp_w    [2];

    // Fault configuration: 0 none, 1 stuck-at bit, 2 address alias src->dst
    int         fault_kind = 0;
    logic [1:0] fault_addr = '0;
    int         fault_bit  = 0;
    logic       fault_val  = 1'b0;
    logic [1:0] alias_src  = '0;
    logic [1:0] alias_dst  = '0;

    exp_t exp_q_s[$];
    exp_t exp_q_a[$];
    int   n_checks = 0;
    int   n_fails  = 0;

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, expv);
        end
    endtask

    function automatic logic [1:0] eff(input logic [1:0] a);
        return (fault_kind == 2 && a == alias_src) ? alias_dst : a;
    endfunction

    // Run the whole algorithm on an array, counting cycles per op
    function automatic exp_t ref_model(input bit sync);
        logic [7:0] m [DEPTH];
        logic [7:0] bg0, bg1, v, x;
        logic [1:0] a, ea;
        int cyc;
        exp_t r;
        r = '0;
        cyc = 0;
        for (int p = 0; p < 2; p++) begin
            bg0 = (p == 1) ? 8'h55 : 8'h00;
            bg1 = (p == 1) ? 8'hAA : 8'hFF;
            for (int e = 0; e < 6; e++) begin
                for (int k = 0; k < DEPTH; k++) begin
                    a = EL_DOWN[e] ? 2'(DEPTH - 1 - k) : 2'(k);
                    if (EL_RD[e]) begin
                        cyc += sync ? 2 : 1;
                        ea = eff(a);
                        v = m[ea];
                        if (fault_kind == 1 && ea == fault_addr) v[fault_bit] = fault_val;
                        x = EL_RPOL[e] ? bg1 : bg0;
                        if (v !== x) begin
                            r.fail = 1'b1;
                            r.addr = a;
                            r.data = v;
                            r.expv = x;
                            r.len  = 32'(cyc);
                            return r;
                        end
                    end
                    if (EL_WR[e]) begin
                        cyc += 1;
                        m[eff(a)] = EL_WPOL[e] ? bg1 : bg0;
                    end
                end
            end
        end
        r.len = 32'(cyc);
        return r;
    endfunction

    for (genvar gi = 0; gi < 2; gi++) begin : g_inst
        logic [7:0] mem_arr [DEPTH];
        logic [7:0] rd_q = '0;
        logic [7:0] rd_a;
        logic [7:0] rd;
        logic [1:0] ea;

        always_comb begin
            ea   = (fault_kind == 2 && mem_addr_w[gi] == alias_src) ? alias_dst : mem_addr_w[gi];
            rd_a = mem_arr[ea];
            if (fault_kind == 1 && ea == fault_addr) rd_a[fault_bit] = fault_val;
        end

        always @(posedge clk) begin
            if (mem_wen_w[gi]) mem_arr[ea] <= mem_wr_data_w[gi];
            if (mem_ren_w[gi]) rd_q <= rd_a;
        end

        assign rd = (gi == 0) ? rd_q : rd_a;

        memory_bist #(
            .DATA_WIDTH(8),
            .ADDR_WIDTH(2),
            .DEPTH     (DEPTH),
            .SYNC_READ ((gi == 0) ? 1 : 0)
        ) dut (
            .clk        (clk),
            .res        (res),
            .start      (start),
            .mem_wen    (mem_wen_w[gi]),
            .mem_ren    (mem_ren_w[gi]),
            .mem_addr   (mem_addr_w[gi]),
            .mem_wr_data(mem_wr_data_w[gi]),
            .mem_rd_data(rd),
            .busy       (busy_w[gi]),
            .done       (done_w[gi]),
            .fail       (fail_w[gi]),
            .fail_addr  (fail_addr_w[gi]),
            .fail_data  (fail_data_w[gi]),
            .fail_exp   (fail_exp_w[gi])
        );

        // Monitor: count busy cycles, pop the expectation when done rises
        initial begin : mon
            int   cnt;
            logic busy_prev, done_prev, have;
            exp_t e;
            cnt = 0;
            busy_prev = 1'b0;
            done_prev = 1'b0;
            forever begin
                @(negedge clk);
                if (busy_w[gi]) cnt = busy_prev ? cnt + 1 : 1;
                if (!busy_w[gi])
                    chk($sformatf("quiet_when_idle[%0d]", gi),
                        {22'd0, mem_wen_w[gi], mem_ren_w[gi], mem_wr_data_w[gi]}, 32'd0);
                if (done_w[gi] && !done_prev) begin
                    have = 1'b0;
                    e = '0;
                    if (gi == 0 && exp_q_s.size() > 0) begin e = exp_q_s.pop_front(); have = 1'b1; end
                    if (gi == 1 && exp_q_a.size() > 0) begin e = exp_q_a.pop_front(); have = 1'b1; end
                    chk($sformatf("expected_run[%0d]", gi), 32'(have), 32'd1);
                    chk($sformatf("fail[%0d]", gi), 32'(fail_w[gi]), 32'(e.fail));
                    chk($sformatf("fail_addr[%0d]", gi), 32'(fail_addr_w[gi]), 32'(e.addr));
                    chk($sformatf("fail_data[%0d]", gi), 32'(fail_data_w[gi]), 32'(e.data));
                    chk($sformatf("fail_exp[%0d]", gi), 32'(fail_exp_w[gi]), 32'(e.expv));
                    chk($sformatf("run_length[%0d]", gi), 32'(cnt), e.len);
                    $display("run[%0d] done: fail=%0d addr=%0d data=0x%02h exp=0x%02h cycles=%0d",
                             gi, fail_w[gi], fail_addr_w[gi], fail_data_w[gi], fail_exp_w[gi], cnt);
                end
                busy_prev = busy_w[gi];
                done_prev = done_w[gi];
            end
        end
    end

    task automatic run(input int kind, input logic [1:0] fa, input int fb, input logic fv,
                       input logic [1:0] src, input logic [1:0] dst, input int mid);
        int i;
        fault_kind = kind;
        fault_addr = fa;
        fault_bit  = fb;
        fault_val  = fv;
        alias_src  = src;
        alias_dst  = dst;
        exp_q_s.push_back(ref_model(1'b1));
        exp_q_a.push_back(ref_model(1'b0));
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 2; k++)
            chk($sformatf("start_clears[%0d]", k),
                32'({busy_w[k], done_w[k], fail_w[k], fail_addr_w[k]}), 32'(5'b10000));
        if (mid > 0) begin
            repeat (mid) @(negedge clk);
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
        i = 0;
        while (i < 400 && !(done_w[0] && done_w[1])) begin
            @(negedge clk);
            i++;
        end
        chk("run_timeout", 32'(done_w[0] && done_w[1]), 32'd1);
        @(negedge clk);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        for (int k = 0; k < 2; k++)
            chk($sformatf("reset_outputs[%0d]", k),
                {busy_w[k], done_w[k], fail_w[k], mem_wen_w[k], mem_ren_w[k], mem_addr_w[k],
                 mem_wr_data_w[k], fail_addr_w[k], fail_data_w[k], fail_exp_w[k]}, 32'd0);
        res = 1'b0;
        @(negedge clk);

        run(0, 2'd0, 0, 1'b0, 2'd0, 2'd0, 0);   // healthy
        run(1, 2'd2, 0, 1'b1, 2'd0, 2'd0, 0);   // bit 0 of addr 2 stuck at 1
        run(2, 2'd0, 0, 1'b0, 2'd3, 2'd1, 0);   // addr 3 aliases addr 1
        run(0, 2'd0, 0, 1'b0, 2'd0, 2'd0, 0);   // restart after a failing run
        run(0, 2'd0, 0, 1'b0, 2'd0, 2'd0, 10);  // start while busy is ignored

        // Abort with res 30 cycles into a run
        fault_kind = 0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (29) @(negedge clk);
        res = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 2; k++)
            chk($sformatf("abort_quiet[%0d]", k),
                32'({busy_w[k], done_w[k], mem_wen_w[k], mem_ren_w[k]}), 32'd0);
        res = 1'b0;
        @(negedge clk);
        run(0, 2'd0, 0, 1'b0, 2'd0, 2'd0, 0);

        for (int t = 0; t < 12; t++) begin
            logic [1:0] s;
            s = 2'($urandom_range(0, 3));
            run($urandom_range(0, 2), 2'($urandom_range(0, 3)), $urandom_range(0, 7),
                1'($urandom_range(0, 1)), s, s + 2'($urandom_range(1, 3)), 0);
        end

        chk("sync_queue_drained", 32'(exp_q_s.size()), 32'd0);
        chk("async_queue_drained", 32'(exp_q_a.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
